// File: rtl/mem_test_initiator.sv
// mem_test_initiator: write-then-readback self-test engine driving a valid/ready memory port
module mem_test_initiator #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 40,
    parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter logic [WIDTH-1:0] SEED = WIDTH'(8'hA5)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pattern_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  mem_valid,
    output logic                  mem_wr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ready
);
    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_CAP, DONE} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, addr_q, addr_d, ferr_q, ferr_d;
    logic [ADDR_WIDTH:0]   err_q, err_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  sel_q, sel_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                  valid_q, valid_d, wr_q, wr_d;
    logic                  accept, mism;
    logic [ADDR_WIDTH-1:0] cnt_inc;
    function automatic logic [WIDTH-1:0] exp_f(input logic [ADDR_WIDTH-1:0] a, input logic s);
        logic [WIDTH-1:0] v;
        v = WIDTH'(a) ^ SEED;
        return s ? ~v : v;
    endfunction
    assign accept  = valid_q & mem_ready;
    assign cnt_inc = cnt_q + 1'b1;
    assign mism    = mem_rdata != exp_f(cnt_q, sel_q);
    // next-state and registered-output values; read data is compared one edge after read acceptance
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        valid_d = valid_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = WR_REQ;
                sel_d   = pattern_sel;
                cnt_d   = '0;
                err_d   = '0;
                ferr_d  = '0;
                pass_d  = 1'b0;
                busy_d  = 1'b1;
                valid_d = 1'b1;
                wr_d    = 1'b1;
                addr_d  = '0;
                wdata_d = exp_f('0, pattern_sel);
            end
            WR_REQ: if (accept) begin
                if (cnt_q == LAST) begin
                    state_d = RD_REQ;
                    cnt_d   = '0;
                    wr_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                end else begin
                    cnt_d   = cnt_inc;
                    addr_d  = cnt_inc;
                    wdata_d = exp_f(cnt_inc, sel_q);
                end
            end
            RD_REQ: if (accept) begin
                state_d = RD_CAP;
                valid_d = 1'b0;
            end
            RD_CAP: begin
                if (mism) begin
                    err_d  = (err_q == '1) ? err_q : err_q + 1'b1;
                    ferr_d = (err_q == '0) ? cnt_q : ferr_q;
                end
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = err_d == '0;
                end else begin
                    state_d = RD_REQ;
                    cnt_d   = cnt_inc;
                    valid_d = 1'b1;
                    addr_d  = cnt_inc;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_q;
    assign mem_valid      = valid_q;
    assign mem_wr_rd      = wr_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
endmodule

// File: tb/tb_mem_test_initiator.sv
// tb_mem_test_initiator: scoreboard bench with a behavioural memory for mem_test_initiator
module tb_mem_test_initiator;
    localparam int DEPTH = 40;
    localparam int AW = 6;
    localparam int W = 8;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, pattern_sel = 1'b0, mem_ready = 1'b0;
    logic [W-1:0] mem_rdata = '0;
    logic busy, done, pass, mem_valid, mem_wr_rd;
    logic [AW:0] err_count;
    logic [AW-1:0] first_err_addr, mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem [DEPTH];
    logic fault_en = 1'b0, rnd_en = 1'b0;
    int n_chk = 0, n_fail = 0, n_done = 0;
    typedef struct packed {logic [AW-1:0] a; logic [W-1:0] d;} wr_t;
    typedef struct packed {logic p; logic [AW:0] e; logic [AW-1:0] f;} res_t;
    wr_t wq[$];
    res_t rq[$];
    wr_t we;
    res_t re;
    logic [AW+W:0] pv;
    logic pend = 1'b0;

    always #5 clk = ~clk;

    mem_test_initiator #(.WIDTH(W), .DEPTH(DEPTH), .SEED(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern_sel(pattern_sel),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    function automatic logic [W-1:0] model(input int a, input logic s);
        logic [W-1:0] v;
        v = W'(a) ^ 8'hA5;
        return s ? ~v : v;
    endfunction

    function automatic logic [W-1:0] rd_word(input int a);
        logic [W-1:0] v;
        v = mem[a];
        if (fault_en && a == 5) v[0] = 1'b1;
        if (fault_en && a == 12) v = ~v;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // memory: sticky or random ready, read data valid only on the edge after acceptance
    always @(posedge clk) begin
        mem_ready <= rnd_en ? 1'($urandom_range(0, 1)) : (mem_ready | mem_valid);
        mem_rdata <= W'($urandom);
        if (mem_valid && mem_ready) begin
            if (mem_wr_rd) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= rd_word(int'(mem_addr));
        end
    end

    // monitor: pops expected writes and results as the DUT presents them
    always @(posedge clk) begin
        if (rst) pend <= 1'b0;
        else begin
            if (pend) check("req_stable", {mem_valid, mem_wr_rd, mem_addr, mem_wdata}, {1'b1, pv});
            pend <= mem_valid && !mem_ready;
            pv <= {mem_wr_rd, mem_addr, mem_wdata};
            if (mem_valid && mem_ready) begin
                if (mem_wr_rd) begin
                    if (wq.size() == 0) fail("wr_unexpected");
                    else begin
                        we = wq.pop_front();
                        check("wr_req", {mem_addr, mem_wdata}, we);
                    end
                end else check("rd_wdata_zero", mem_wdata, 0);
            end
            if (done) begin
                n_done++;
                if (rq.size() == 0) fail("done_unexpected");
                else begin
                    re = rq.pop_front();
                    check("result", {pass, err_count, first_err_addr}, re);
                end
            end
        end
    end

    task automatic arm(input logic sel, input logic f, input logic r, input logic p, input int e, input int fa);
        pattern_sel = sel;
        fault_en = f;
        rnd_en = r;
        for (int a = 0; a < DEPTH; a++) wq.push_back(wr_t'({AW'(a), model(a, sel)}));
        rq.push_back(res_t'({p, (AW+1)'(e), AW'(fa)}));
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_at_accept", busy, 1);
        check("pass_cleared", pass, 0);
    endtask

    task automatic wait_done(input int budget, input bit restart);
        int c = 0;
        while (!done && c < budget) begin
            if (restart && c == 20) start = 1'b1;
            tick();
            start = 1'b0;
            c++;
        end
        if (!done) fail("done_timeout");
    endtask

    task automatic after_done(input logic p);
        check("pass_at_done", pass, p);
        check("busy_low_at_done", busy, 0);
        tick();
        check("done_one_cycle", done, 0);
        check("pass_held", pass, p);
        repeat (3) tick();
    endtask

    initial begin
        int d0, c;
        repeat (2) tick();
        check("reset_outputs", {busy, done, pass, err_count, first_err_addr, mem_valid, mem_wr_rd, mem_addr, mem_wdata}, 0);
        rst = 1'b0;
        tick();
        arm(0, 0, 0, 1, 0, 0);
        go();
        wait_done(3 * DEPTH + 4, 0);
        after_done(1);
        check("t1_mem3", mem[3], 8'hA6);
        check("t1_mem39", mem[39], 8'h82);
        arm(1, 0, 0, 1, 0, 0);
        go();
        wait_done(3 * DEPTH + 4, 0);
        after_done(1);
        check("t2_mem3", mem[3], 8'h59);
        check("t2_mem10", mem[10], 8'h50);
        arm(0, 1, 0, 0, 2, 5);
        go();
        wait_done(3 * DEPTH + 4, 0);
        check("t3_err_count", err_count, 2);
        check("t3_first_err", first_err_addr, 5);
        after_done(0);
        arm(0, 0, 1, 1, 0, 0);
        go();
        wait_done(20 * DEPTH + 50, 0);
        after_done(1);
        arm(0, 0, 0, 1, 0, 0);
        go();
        c = 0;
        while (!(mem_valid && mem_wr_rd && mem_addr == 17) && c < 200) begin
            tick();
            c++;
        end
        if (c >= 200) fail("addr17_timeout");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_reset", {busy, done, pass, err_count, first_err_addr, mem_valid, mem_wr_rd, mem_addr, mem_wdata}, 0);
        wq.delete();
        rq.delete();
        tick();
        d0 = n_done;
        arm(0, 0, 0, 1, 0, 0);
        go();
        wait_done(3 * DEPTH + 4, 1);
        after_done(1);
        check("single_done", n_done, d0 + 1);
        arm(0, 0, 0, 1, 0, 0);
        go();
        wait_done(3 * DEPTH + 4, 0);
        check("b2b_first_pass", pass, 1);
        arm(1, 0, 0, 1, 0, 0);
        start = 1'b1;
        tick();
        check("start_in_done_ignored", busy, 0);
        tick();
        start = 1'b0;
        check("b2b_accepted", busy, 1);
        check("b2b_pass_cleared", pass, 0);
        wait_done(3 * DEPTH + 4, 0);
        after_done(1);
        check("wq_drained", wq.size(), 0);
        check("rq_drained", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
